obuf_drain: RTL

- Drains bytes that the eJ32 outer interpreter writes into the output buffer (OBUF ring at OBUF..OBUF+OSZ-1).
- Streams them out one at a time on a valid/ready byte stream toward a console/UART sink.
- Sits directly downstream of the CPU/dictionary memory. It fetches over a shared 8-bit memory read port with request/grant arbitration.
- The producer publishes a write offset (head). This block owns and exports the read offset (tail).

---
 rtl/obuf_drain.sv | 128 ++++++++++++
 1 files changed

// File: rtl/obuf_drain.sv
// Purpose : drains the eJ32 output ring (OBUF..OBUF+OSZ-1) onto a byte stream for the console sink.
// Latency : head!=tail seen in IDLE -> mem_req next cycle -> tx_valid two edges after the granted read.
// Backpress: tx_ready low holds tx_data/tx_valid in OUT; mem_gnt low holds mem_req/mem_a in REQ.
//
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   head           producer write offset (next free slot)
//   mem_req/gnt    shared memory read arbitration; read happens on mem_req & mem_gnt
//   mem_a, mem_d   read address (OBUF+tail); data returned the cycle after the grant
//   tx_data/valid/ready  outgoing byte stream
//   tail           read offset (next byte to fetch), owned here
//   empty          idle with nothing pending
//   cnt            bytes delivered, wraps at 2^16
//   err            sticky: an out-of-range head was seen in IDLE
module obuf_drain #(
   parameter int OBUF = 'h1400,
   parameter int OSZ  = 'h600,
   parameter int ASZ  = 17,
   parameter int OW   = $clog2(OSZ)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [OW-1:0] head,
   output logic          mem_req,
   input  logic          mem_gnt,
   output logic [ASZ-1:0] mem_a,
   input  logic [7:0]    mem_d,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic [OW-1:0] tail,
   output logic          empty,
   output logic [15:0]   cnt,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, REQ, DATA, OUT} state_t;

   localparam logic [ASZ-1:0] BASE = ASZ'(OBUF);
   localparam logic [OW-1:0]  LAST = OW'(OSZ - 1);
   localparam logic [OW-1:0]  SZ   = OW'(OSZ);
   // With a power-of-two ring every head value is legal.
   localparam bit             POW2 = (OSZ == (1 << OW));

   state_t         state, state_nxt;
   logic [OW-1:0]  tail_nxt, tail_inc;
   logic           mem_req_nxt, tx_valid_nxt, err_nxt;
   logic [ASZ-1:0] mem_a_nxt;
   logic [7:0]     tx_data_nxt;
   logic [15:0]    cnt_nxt;
   logic           head_bad;

   assign head_bad = !POW2 && (head >= SZ);
   assign tail_inc = (tail == LAST) ? '0 : tail + 1'b1;
   assign empty    = (state == IDLE) && (head == tail);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         tail     <= '0;
         mem_req  <= 1'b0;
         mem_a    <= BASE;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         cnt      <= 16'h0000;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         tail     <= tail_nxt;
         mem_req  <= mem_req_nxt;
         mem_a    <= mem_a_nxt;
         tx_data  <= tx_data_nxt;
         tx_valid <= tx_valid_nxt;
         cnt      <= cnt_nxt;
         err      <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      tail_nxt     = tail;
      mem_req_nxt  = mem_req;
      mem_a_nxt    = mem_a;
      tx_data_nxt  = tx_data;
      tx_valid_nxt = tx_valid;
      cnt_nxt      = cnt;
      err_nxt      = err;
      unique case (state)
         IDLE: begin
            if (head_bad) begin
               err_nxt = 1'b1;
            end else if (head != tail) begin
               mem_req_nxt = 1'b1;
               mem_a_nxt   = BASE + ASZ'(tail);
               state_nxt   = REQ;
            end
         end
         REQ: begin
            if (mem_gnt) begin
               mem_req_nxt = 1'b0;
               state_nxt   = DATA;
            end
         end
         DATA: begin
            tx_data_nxt  = mem_d;
            tx_valid_nxt = 1'b1;
            state_nxt    = OUT;
         end
         OUT: begin
            if (tx_ready) begin
               tx_valid_nxt = 1'b0;
               cnt_nxt      = cnt + 16'd1;
               tail_nxt     = tail_inc;
               // Chain straight into the next fetch to skip an IDLE cycle.
               if ((head != tail_inc) && !head_bad) begin
                  mem_req_nxt = 1'b1;
                  mem_a_nxt   = BASE + ASZ'(tail_inc);
                  state_nxt   = REQ;
               end else begin
                  state_nxt   = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
